// File: rtl/twobit_mesh_row_unloader.sv
// Unload side of the two-bit mesh: waits a fixed latency after the `high`
// rising edge, snapshots the flat mesh result into a frame buffer and then
// streams it out one row per valid/ready handshake.
module twobit_mesh_row_unloader #(
    parameter int COLS    = 26,
    parameter int ROWS    = 18,
    parameter int ROW_W   = 5,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   high,
    input  logic [COLS*ROWS-1:0]   mesh_out,
    output logic [COLS-1:0]        rd_data,
    output logic [ROW_W-1:0]       rd_row,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   rd_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [3:0]       LAT_C    = 4'(LATENCY);

    state_t                 state_q;
    state_t                 state_d;
    logic                   high_q;
    logic [3:0]             lat_cnt_q;
    logic [3:0]             lat_cnt_d;
    logic [ROW_W-1:0]       row_idx_q;
    logic [ROW_W-1:0]       row_idx_d;
    logic                   overrun_q;
    logic                   overrun_d;
    logic                   done_q;
    logic                   done_d;
    logic                   cap_s;
    logic                   start_s;
    logic [COLS*ROWS-1:0]   frame_q;
    logic [COLS-1:0]        rd_data_s;

    // Rising edge of the shared compute strobe; a held-high strobe starts once.
    assign start_s = high & ~high_q;

    // Control state, counters, strobe history and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            high_q    <= 1'b0;
            lat_cnt_q <= 4'd0;
            row_idx_q <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            high_q    <= high;
            lat_cnt_q <= lat_cnt_d;
            row_idx_q <= row_idx_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    // Frame buffer: mesh_out is sampled only on the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (cap_s) begin
            frame_q <= mesh_out;
        end else begin
            frame_q <= frame_q;
        end
    end

    // Next-state logic: latency count, capture, row sequencing, overrun.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        row_idx_d = row_idx_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        cap_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = 4'd1;
                    overrun_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A second start while busy is only flagged, never acted on.
                if (start_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (lat_cnt_q == LAT_C) begin
                    cap_s     = 1'b1;
                    row_idx_d = '0;
                    state_d   = ST_STREAM;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            ST_STREAM: begin
                if (start_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (rd_ready) begin
                    if (row_idx_q == LAST_ROW) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        row_idx_d = '0;
                    end else begin
                        row_idx_d = row_idx_q + {{(ROW_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    row_idx_d = row_idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Row mux from the frame buffer; forced to zero when no row is valid.
    always_comb begin
        if (state_q == ST_STREAM) begin
            rd_data_s = frame_q[int'(row_idx_q)*COLS +: COLS];
        end else begin
            rd_data_s = '0;
        end
    end

    assign rd_data  = rd_data_s;
    assign rd_row   = row_idx_q;
    assign rd_valid = (state_q == ST_STREAM);
    assign rd_last  = (state_q == ST_STREAM) && (row_idx_q == LAST_ROW);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule
